// File: rtl/pps_seq_pkg.sv
// Shared op encodings and overflow-policy constants for the PC sequencer group.
package pps_seq_pkg;

    localparam logic [2:0] OP_NEXT  = 3'b000;
    localparam logic [2:0] OP_JMP   = 3'b001;
    localparam logic [2:0] OP_LJMP  = 3'b010;
    localparam logic [2:0] OP_CALL  = 3'b011;
    localparam logic [2:0] OP_LCALL = 3'b100;
    localparam logic [2:0] OP_RET   = 3'b101;
    localparam logic [2:0] OP_RETSK = 3'b110;
    localparam logic [2:0] OP_HOLD  = 3'b111;

    localparam int unsigned OVF_DROP   = 0;
    localparam int unsigned OVF_REFUSE = 1;

endpackage

// File: rtl/pps_ret_stack.sv
// Return stack with the top at index 0; pops refill the bottom entry with zero.
module pps_ret_stack
    import pps_seq_pkg::*;
#(
    parameter int unsigned DEPTH    = 5,
    parameter int unsigned WIDTH    = 10,
    parameter int unsigned OVF_MODE = OVF_DROP,
    localparam int unsigned CW      = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty,
    output logic             ovf,
    output logic             unf
);

    logic [WIDTH-1:0] mem [DEPTH];

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign ovf   = push & full;
    assign unf   = pop & empty;
    assign dout  = empty ? '0 : mem[0];

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
            count <= '0;
        end else if (push) begin
            // A full push in drop mode shifts the oldest entry out of the bottom.
            if (!full || OVF_MODE == OVF_DROP) begin
                for (int unsigned i = DEPTH - 1; i > 0; i--) mem[i] <= mem[i-1];
                mem[0] <= din;
                if (!full) count <= count + CW'(1);
            end
        end else if (pop && !empty) begin
            for (int unsigned i = 0; i < DEPTH - 1; i++) mem[i] <= mem[i+1];
            mem[DEPTH-1] <= '0;
            count        <= count - CW'(1);
        end
    end

endmodule

// File: rtl/pps_pc_sequencer.sv
// Program-counter sequencer: LFSR in-page counter, page register and return stack.
module pps_pc_sequencer
    import pps_seq_pkg::*;
#(
    parameter int unsigned     PL_W      = 6,
    parameter int unsigned     PU_W      = 4,
    parameter int unsigned     DEPTH     = 5,
    parameter int unsigned     TAP       = 1,
    parameter logic [PU_W-1:0] CALL_PAGE = '1,
    parameter int unsigned     OVF_MODE  = OVF_DROP
) (
    input  logic                       clk,
    input  logic                       nreset,
    input  logic                       en,
    input  logic [2:0]                 op,
    input  logic [PL_W-1:0]            target,
    input  logic [PU_W-1:0]            page,
    input  logic                       err_clr,
    output logic [PU_W+PL_W-1:0]       pc,
    output logic                       skip,
    output logic [$clog2(DEPTH+1)-1:0] sp_count,
    output logic                       stk_full,
    output logic                       stk_empty,
    output logic                       ovf_err,
    output logic                       unf_err
);

    logic [PU_W-1:0] pu, nxt_pu;
    logic [PL_W-1:0] pl, nxt_pl, adv_pl;
    logic            nxt_skip, push, pop, stk_ovf, stk_unf;
    logic [PU_W+PL_W-1:0] stk_top;

    // All-ones is a fixed point of this XNOR feedback and is intentionally kept.
    assign adv_pl = {pl[0] ~^ pl[TAP], pl[PL_W-1:1]};
    assign pc     = {pu, pl};

    always_comb begin
        nxt_pu   = pu;
        nxt_pl   = pl;
        nxt_skip = skip;
        push     = 1'b0;
        pop      = 1'b0;
        if (en) begin
            nxt_skip = (op == OP_RETSK);
            unique case (op)
                OP_NEXT:  nxt_pl = adv_pl;
                OP_JMP:   nxt_pl = target;
                OP_LJMP:  {nxt_pu, nxt_pl} = {page, target};
                OP_CALL:  begin push = 1'b1; {nxt_pu, nxt_pl} = {CALL_PAGE, target}; end
                OP_LCALL: begin push = 1'b1; {nxt_pu, nxt_pl} = {page, target}; end
                OP_RET,
                OP_RETSK: begin pop = 1'b1; {nxt_pu, nxt_pl} = stk_top; end
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            pu      <= '0;
            pl      <= '0;
            skip    <= 1'b0;
            ovf_err <= 1'b0;
            unf_err <= 1'b0;
        end else begin
            pu   <= nxt_pu;
            pl   <= nxt_pl;
            skip <= nxt_skip;
            if (stk_ovf)      ovf_err <= 1'b1;
            else if (err_clr) ovf_err <= 1'b0;
            if (stk_unf)      unf_err <= 1'b1;
            else if (err_clr) unf_err <= 1'b0;
        end
    end

    pps_ret_stack #(
        .DEPTH    (DEPTH),
        .WIDTH    (PU_W + PL_W),
        .OVF_MODE (OVF_MODE)
    ) u_stack (
        .clk    (clk),
        .nreset (nreset),
        .push   (push),
        .pop    (pop),
        .din    ({pu, adv_pl}),
        .dout   (stk_top),
        .count  (sp_count),
        .full   (stk_full),
        .empty  (stk_empty),
        .ovf    (stk_ovf),
        .unf    (stk_unf)
    );

endmodule

// File: tb/tb_pps_pc_sequencer.sv
// Directed bench: drop-policy and refuse-policy instances driven in lockstep.
module tb_pps_pc_sequencer;
    import pps_seq_pkg::*;

    logic       clk = 1'b0;
    logic       nreset = 1'b0;
    logic       en = 1'b0;
    logic [2:0] op = OP_HOLD;
    logic [5:0] target = '0;
    logic [3:0] page = '0;
    logic       err_clr = 1'b0;

    logic [9:0] pc0, pc1;
    logic       skip0, skip1, full0, full1, empty0, empty1;
    logic       ovf0, ovf1, unf0, unf1;
    logic [2:0] sp0, sp1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pps_pc_sequencer #(.OVF_MODE(OVF_DROP)) dut0 (
        .clk(clk), .nreset(nreset), .en(en), .op(op), .target(target), .page(page),
        .err_clr(err_clr), .pc(pc0), .skip(skip0), .sp_count(sp0), .stk_full(full0),
        .stk_empty(empty0), .ovf_err(ovf0), .unf_err(unf0)
    );

    pps_pc_sequencer #(.OVF_MODE(OVF_REFUSE)) dut1 (
        .clk(clk), .nreset(nreset), .en(en), .op(op), .target(target), .page(page),
        .err_clr(err_clr), .pc(pc1), .skip(skip1), .sp_count(sp1), .stk_full(full1),
        .stk_empty(empty1), .ovf_err(ovf1), .unf_err(unf1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One accepted op; returns 1 ns after the accepting edge.
    task automatic do_op(input logic [2:0] o, input logic [5:0] t, input logic [3:0] p,
                         input logic clr);
        en = 1'b1; op = o; target = t; page = p; err_clr = clr;
        @(posedge clk); #1;
        en = 1'b0; op = OP_HOLD; err_clr = 1'b0;
    endtask

    task automatic idle(input logic clr);
        en = 1'b0; op = OP_NEXT; err_clr = clr;
        @(posedge clk); #1;
        op = OP_HOLD; err_clr = 1'b0;
    endtask

    task automatic chk_both(input string tag, input logic [3:0] pu, input logic [5:0] pl,
                            input logic [2:0] sp);
        check({tag, " pc0"}, 32'(pc0), 32'({pu, pl}));
        check({tag, " pc1"}, 32'(pc1), 32'({pu, pl}));
        check({tag, " sp0"}, 32'(sp0), 32'(sp));
        check({tag, " sp1"}, 32'(sp1), 32'(sp));
    endtask

    logic [5:0] next_seq [6] = '{6'd32, 6'd48, 6'd56, 6'd60, 6'd62, 6'd31};
    logic [3:0] call_pg  [6] = '{4'd1, 4'd2, 4'd4, 4'd5, 4'd6, 4'd7};
    logic [5:0] call_tg  [6] = '{6'd10, 6'd20, 6'd12, 6'd3, 6'd17, 6'd25};
    // Return addresses pushed by the six LCALLs, oldest first.
    logic [9:0] ret_addr [6] = '{{4'd3, 6'd32}, {4'd1, 6'd5}, {4'd2, 6'd42},
                                 {4'd4, 6'd38}, {4'd5, 6'd33}, {4'd6, 6'd8}};

    initial begin
        #12;
        chk_both("reset", 4'd0, 6'd0, 3'd0);
        check("reset skip", 32'(skip0), 32'd0);
        check("reset empty", 32'(empty0), 32'd1);
        check("reset full", 32'(full0), 32'd0);
        check("reset ovf", 32'(ovf0), 32'd0);
        check("reset unf", 32'(unf0), 32'd0);
        @(negedge clk); nreset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            do_op(OP_NEXT, '0, '0, 1'b0);
            chk_both("next", 4'd0, next_seq[i], 3'd0);
        end

        do_op(OP_LJMP, 6'd5, 4'd3, 1'b0);
        chk_both("ljmp", 4'd3, 6'd5, 3'd0);
        do_op(OP_CALL, 6'd7, 4'd9, 1'b0);
        chk_both("call", 4'd15, 6'd7, 3'd1);
        do_op(OP_RET, '0, '0, 1'b0);
        chk_both("ret", 4'd3, 6'd2, 3'd0);
        check("ret skip", 32'(skip0), 32'd0);

        do_op(OP_CALL, 6'd9, '0, 1'b0);
        chk_both("call2", 4'd15, 6'd9, 3'd1);
        do_op(OP_RETSK, '0, '0, 1'b0);
        chk_both("retsk", 4'd3, 6'd1, 3'd0);
        check("retsk skip", 32'(skip0), 32'd1);
        for (int i = 0; i < 2; i++) begin
            idle(1'b0);
            check("hold skip", 32'(skip0), 32'd1);
            check("hold pc", 32'(pc0), 32'({4'd3, 6'd1}));
        end
        do_op(OP_NEXT, '0, '0, 1'b0);
        check("skip clr", 32'(skip0), 32'd0);
        check("adv 1", 32'(pc0), 32'({4'd3, 6'd0}));

        for (int i = 0; i < 6; i++) begin
            do_op(OP_LCALL, call_tg[i], call_pg[i], 1'b0);
            chk_both("lcall", call_pg[i], call_tg[i], 3'(i < 5 ? i + 1 : 5));
            check("lcall ovf", 32'(ovf0), 32'(i == 5));
        end
        check("full0", 32'(full0), 32'd1);
        check("ovf1", 32'(ovf1), 32'd1);
        for (int i = 0; i < 5; i++) begin
            do_op(OP_RET, '0, '0, 1'b0);
            check("drop ret", 32'(pc0), 32'(ret_addr[5 - i]));
            check("refuse ret", 32'(pc1), 32'(ret_addr[4 - i]));
        end
        check("unf early", 32'(unf0), 32'd0);
        do_op(OP_RET, '0, '0, 1'b0);
        chk_both("underflow", 4'd0, 6'd0, 3'd0);
        check("unf0", 32'(unf0), 32'd1);
        check("unf1", 32'(unf1), 32'd1);
        check("empty1", 32'(empty1), 32'd1);

        idle(1'b1);
        check("clr ovf", 32'(ovf0), 32'd0);
        check("clr unf", 32'(unf0), 32'd0);

        for (int i = 0; i < 6; i++) do_op(OP_CALL, 6'(i), '0, 1'b0);
        check("re-ovf", 32'(ovf0), 32'd1);
        do_op(OP_CALL, 6'd40, '0, 1'b1);
        check("set wins", 32'(ovf0), 32'd1);
        check("set wins1", 32'(ovf1), 32'd1);
        check("call pc", 32'(pc0), 32'({4'd15, 6'd40}));
        idle(1'b1);
        check("clr alone ovf", 32'(ovf0), 32'd0);
        check("clr alone unf", 32'(unf0), 32'd0);

        do_op(OP_RET, '0, '0, 1'b0);
        do_op(OP_RETSK, '0, '0, 1'b0);
        check("pre-rst sp", 32'(sp0), 32'd3);
        check("pre-rst skip", 32'(skip0), 32'd1);
        #1 nreset = 1'b0;
        #1;
        chk_both("async rst", 4'd0, 6'd0, 3'd0);
        check("rst skip", 32'(skip0), 32'd0);
        check("rst ovf", 32'(ovf0), 32'd0);
        @(negedge clk); nreset = 1'b1;
        @(posedge clk); #1;
        do_op(OP_RET, '0, '0, 1'b0);
        chk_both("post-rst ret", 4'd0, 6'd0, 3'd0);
        check("post-rst unf", 32'(unf0), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
